// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared register map and sizing for the push-button debouncer
package button_debounce_pkg;
    localparam logic [1:0] ADDR_LEVEL   = 2'd0;
    localparam logic [1:0] ADDR_CAPTURE = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    localparam int N_BTN_MAX   = 4;
    localparam int PRESS_CNT_W = 8;
endpackage

// File: rtl/button_debounce_bit.sv
// rtl/button_debounce_bit.sv - synchronizer, active-high inversion and stability counter for one button
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_pulse_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             synced;
    logic             accept;

    always_comb begin
        sync1_d = btn_raw_i;
        sync2_d = sync1_q;
        synced  = ~sync2_q;
        level_d = level_q;
        cnt_d   = '0;
        accept  = 1'b0;
        // Any sample that matches the current level restarts the count.
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced;
                accept  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Combinational so register-file consumers update on the same edge as level_o.
    assign press_pulse_o = accept & synced;
    assign level_o       = level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced buttons with capture, mask, press counters and Avalon-MM polling
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] btn_o,
    input  logic [1:0]       s0_address,
    input  logic             s0_read,
    input  logic             s0_write,
    output logic [31:0]      s0_readdata,
    input  logic [31:0]      s0_writedata,
    output logic             irq_o
);
    logic [N_BTN-1:0]       level;
    logic [N_BTN-1:0]       press;
    logic [N_BTN-1:0]       capture_q, capture_d;
    logic [N_BTN-1:0]       mask_q, mask_d;
    logic [PRESS_CNT_W-1:0] count_q [N_BTN];
    logic [PRESS_CNT_W-1:0] count_d [N_BTN];
    logic [31:0]            readdata_q, readdata_d;
    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk          (clk),
            .reset_n      (reset_n),
            .btn_raw_i    (btn_raw_i[i]),
            .level_o      (level[i]),
            .press_pulse_o(press[i])
        );
    end

    assign unused_wdata = ^s0_writedata;

    always_comb begin
        rd_mux = '0;
        case (s0_address)
            ADDR_LEVEL:   rd_mux[N_BTN-1:0] = level;
            ADDR_CAPTURE: rd_mux[N_BTN-1:0] = capture_q;
            ADDR_MASK:    rd_mux[N_BTN-1:0] = mask_q;
            default: begin
                for (int i = 0; i < N_BTN; i++) begin
                    rd_mux[PRESS_CNT_W*i +: PRESS_CNT_W] = count_q[i];
                end
            end
        endcase
    end

    always_comb begin
        readdata_d = s0_read ? rd_mux : readdata_q;
        mask_d     = mask_q;
        capture_d  = capture_q;
        if (s0_write && s0_address == ADDR_MASK) begin
            mask_d = s0_writedata[N_BTN-1:0];
        end
        if (s0_write && s0_address == ADDR_CAPTURE) begin
            capture_d = capture_q & ~s0_writedata[N_BTN-1:0];
        end
        // New presses override a same-cycle clear.
        capture_d = capture_d | press;
        for (int i = 0; i < N_BTN; i++) begin
            if (s0_write && s0_address == ADDR_COUNT) begin
                count_d[i] = press[i] ? PRESS_CNT_W'(1) : '0;
            end else if (press[i]) begin
                count_d[i] = count_q[i] + PRESS_CNT_W'(1);
            end else begin
                count_d[i] = count_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture_q  <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            capture_q  <= capture_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < N_BTN; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign btn_o       = level;
    assign s0_readdata = readdata_q;
    assign irq_o       = |(capture_q & mask_q);
endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  btn_raw_i = 4'hF;
    logic [3:0]  btn_o;
    logic [1:0]  s0_address = 2'd0;
    logic        s0_read = 1'b0;
    logic        s0_write = 1'b0;
    logic [31:0] s0_readdata;
    logic [31:0] s0_writedata = 32'd0;
    logic        irq_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd;
    logic        stayed_low;

    button_debounce #(.N_BTN(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw_i   (btn_raw_i),
        .btn_o       (btn_o),
        .s0_address  (s0_address),
        .s0_read     (s0_read),
        .s0_write    (s0_write),
        .s0_readdata (s0_readdata),
        .s0_writedata(s0_writedata),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        s0_address = a;
        s0_read    = 1'b1;
        step(1);
        s0_read    = 1'b0;
        d          = s0_readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        s0_address   = a;
        s0_writedata = d;
        s0_write     = 1'b1;
        step(1);
        s0_write     = 1'b0;
    endtask

    task automatic press_release(input int b);
        btn_raw_i[b] = 1'b0;
        step(11);
        btn_raw_i[b] = 1'b1;
        step(11);
    endtask

    initial begin
        #12;
        check("reset_btn_o", {28'd0, btn_o}, 32'd0);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        check("reset_readdata", s0_readdata, 32'd0);
        reset_n = 1'b1;
        step(2);

        // Clean press on button 0: level rises exactly 10 edges after the pin edge.
        btn_raw_i[0] = 1'b0;
        step(9);
        check("clean_lat9", {31'd0, btn_o[0]}, 32'd0);
        step(1);
        check("clean_lat10", {31'd0, btn_o[0]}, 32'd1);
        step(10);
        bus_read(2'd1, rd); check("clean_capture", rd, 32'h1);
        bus_read(2'd3, rd); check("clean_count", rd, 32'h00000001);
        bus_read(2'd0, rd); check("clean_level", rd, 32'h1);
        bus_write(2'd1, 32'h1);
        btn_raw_i[0] = 1'b1;
        step(12);
        check("release_level", {28'd0, btn_o}, 32'd0);
        bus_read(2'd1, rd); check("release_no_capture", rd, 32'h0);

        // Writes to LEVEL are ignored.
        bus_write(2'd0, 32'hF);
        bus_read(2'd0, rd); check("level_ro", rd, 32'h0);

        // Bounce on button 2: 8 toggles 5 cycles apart, then a final low edge.
        bus_write(2'd3, 32'h0);
        stayed_low = 1'b1;
        for (int k = 0; k < 8; k++) begin
            btn_raw_i[2] = ~btn_raw_i[2];
            for (int j = 0; j < 5; j++) begin
                step(1);
                if (btn_o[2]) stayed_low = 1'b0;
            end
        end
        check("bounce_no_accept", {31'd0, stayed_low}, 32'd1);
        btn_raw_i[2] = 1'b0;
        step(9);
        check("bounce_lat9", {31'd0, btn_o[2]}, 32'd0);
        step(1);
        check("bounce_lat10", {31'd0, btn_o[2]}, 32'd1);
        btn_raw_i[2] = 1'b1;
        step(12);
        bus_read(2'd3, rd); check("bounce_count", rd, 32'h00010000);
        bus_write(2'd1, 32'hF);

        // Interrupt masking.
        bus_write(2'd2, 32'h2);
        check("irq_idle", {31'd0, irq_o}, 32'd0);
        press_release(1);
        check("irq_set", {31'd0, irq_o}, 32'd1);
        bus_write(2'd1, 32'h2);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        btn_raw_i[3] = 1'b0;
        step(12);
        check("irq_masked", {31'd0, irq_o}, 32'd0);
        bus_read(2'd1, rd); check("masked_capture", rd, 32'h8);
        btn_raw_i[3] = 1'b1;
        step(12);
        bus_write(2'd1, 32'hF);

        // Read and write in one cycle returns the old contents.
        s0_address = 2'd2; s0_writedata = 32'h5; s0_read = 1'b1; s0_write = 1'b1;
        step(1);
        s0_read = 1'b0; s0_write = 1'b0;
        check("rw_old_mask", s0_readdata, 32'h2);
        bus_read(2'd2, rd); check("rw_new_mask", rd, 32'h5);
        bus_write(2'd2, 32'h0);

        // W1C colliding with a button-0 press: the set wins.
        btn_raw_i[0] = 1'b0;
        step(9);
        s0_address = 2'd1; s0_writedata = 32'h1; s0_write = 1'b1;
        step(1);
        s0_write = 1'b0;
        check("coll_w1c_level", {31'd0, btn_o[0]}, 32'd1);
        btn_raw_i[0] = 1'b1;
        step(12);
        bus_read(2'd1, rd); check("coll_w1c_capture", rd, 32'h1);
        bus_read(2'd3, rd); check("coll_pre_count", rd, 32'h01010101);

        // COUNT clear colliding with a button-0 press.
        btn_raw_i[0] = 1'b0;
        step(9);
        s0_address = 2'd3; s0_writedata = 32'h0; s0_write = 1'b1;
        step(1);
        s0_write = 1'b0;
        btn_raw_i[0] = 1'b1;
        step(12);
        bus_read(2'd3, rd); check("coll_count", rd, 32'h00000001);

        // Counter wrap on button 3.
        bus_write(2'd3, 32'h0);
        bus_write(2'd1, 32'hF);
        for (int p = 0; p < 255; p++) press_release(3);
        bus_read(2'd3, rd); check("wrap_255", rd, 32'hFF000000);
        press_release(3);
        bus_read(2'd3, rd); check("wrap_256", rd, 32'h00000000);
        bus_read(2'd1, rd); check("wrap_capture", rd, 32'h8);

        // Asynchronous reset mid-operation with a pending, unmasked capture.
        bus_write(2'd1, 32'hF);
        bus_write(2'd2, 32'hF);
        btn_raw_i[0] = 1'b0;
        step(12);
        bus_read(2'd1, rd); check("pre_reset_capture", rd, 32'h1);
        check("pre_reset_irq", {31'd0, irq_o}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async_btn_o", {28'd0, btn_o}, 32'd0);
        check("async_irq", {31'd0, irq_o}, 32'd0);
        check("async_readdata", s0_readdata, 32'd0);
        step(2);
        reset_n = 1'b1;
        step(3);
        check("post_reset_level", {28'd0, btn_o}, 32'd0);
        bus_read(2'd1, rd); check("post_reset_capture", rd, 32'h0);
        bus_read(2'd2, rd); check("post_reset_mask", rd, 32'h0);
        step(5);
        check("held_level", {31'd0, btn_o[0]}, 32'd1);
        bus_read(2'd1, rd); check("held_capture", rd, 32'h1);
        btn_raw_i[0] = 1'b1;
        step(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
